// File: rtl/tri_raster_stream.sv
// Streaming triangle rasterizer: clips the bounding box to the screen, walks it
// row-major with three edge-function tests, and emits covered pixels as fragments.
module tri_raster_stream #(
    parameter int WIDTH   = 64,
    parameter int HEIGHT  = 64,
    parameter int CW      = 9,
    parameter int COLOR_W = 8,
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                tri_valid,
    output logic                tri_ready,
    input  logic [3*CW-1:0]     tri_x,
    input  logic [3*CW-1:0]     tri_y,
    input  logic [COLOR_W-1:0]  tri_color,
    output logic                frag_valid,
    input  logic                frag_ready,
    output logic [XW-1:0]       frag_x,
    output logic [YW-1:0]       frag_y,
    output logic [COLOR_W-1:0]  frag_color,
    output logic                tri_done,
    output logic                busy
);
    localparam int EW = 2*CW + 3;
    localparam logic [CW-1:0] XLIM = CW'(WIDTH - 1);
    localparam logic [CW-1:0] YLIM = CW'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [3*CW-1:0]    vx, vy;
    logic [COLOR_W-1:0] color_r;
    logic [CW-1:0]      xmin_r, xmax_r, ymax_r;
    logic [CW-1:0]      px, py;
    logic               scan_end;

    logic [CW-1:0]      x0, x1, x2, y0, y1, y2;
    logic [CW-1:0]      xmin_c, ymin_c, xmax_c, ymax_c, xhi_c, yhi_c;
    logic signed [EW-1:0] area_c, e01, e12, e20;
    logic               skip_c, covered, stall;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Eab(q) = (bx-ax)*(qy-ay) - (by-ay)*(qx-ax); EW bits hold it without overflow.
    function automatic logic signed [EW-1:0] edge_fn(input logic [CW-1:0] ax, ay, bx, by, qx, qy);
        logic signed [EW-1:0] dx, dy, qdx, qdy;
        dx  = $signed(EW'(bx)) - $signed(EW'(ax));
        dy  = $signed(EW'(by)) - $signed(EW'(ay));
        qdx = $signed(EW'(qx)) - $signed(EW'(ax));
        qdy = $signed(EW'(qy)) - $signed(EW'(ay));
        return dx * qdy - dy * qdx;
    endfunction

    always_comb begin
        x0 = vx[CW-1:0];  x1 = vx[2*CW-1:CW];  x2 = vx[3*CW-1:2*CW];
        y0 = vy[CW-1:0];  y1 = vy[2*CW-1:CW];  y2 = vy[3*CW-1:2*CW];
        xmin_c = min3(x0, x1, x2);
        ymin_c = min3(y0, y1, y2);
        xhi_c  = max3(x0, x1, x2);
        yhi_c  = max3(y0, y1, y2);
        xmax_c = (xhi_c > XLIM) ? XLIM : xhi_c;
        ymax_c = (yhi_c > YLIM) ? YLIM : yhi_c;
        area_c = edge_fn(x0, y0, x1, y1, x2, y2);
        skip_c = (area_c == '0) || (xmin_c > XLIM) || (ymin_c > YLIM);
        e01 = edge_fn(x0, y0, x1, y1, px, py);
        e12 = edge_fn(x1, y1, x2, y2, px, py);
        e20 = edge_fn(x2, y2, x0, y0, px, py);
        // Inclusive on both windings: all non-negative or all non-positive.
        covered = (!e01[EW-1] && !e12[EW-1] && !e20[EW-1]) ||
                  ((e01 <= 0) && (e12 <= 0) && (e20 <= 0));
        stall = frag_valid && !frag_ready;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tri_ready = 1'b0;
        tri_done  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                tri_ready = 1'b1;
                busy      = 1'b0;
                if (tri_valid) state_nxt = S_SETUP;
            end
            S_SETUP: state_nxt = skip_c ? S_DONE : S_SCAN;
            S_SCAN:  if (scan_end && (!frag_valid || frag_ready)) state_nxt = S_DONE;
            S_DONE: begin
                tri_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vx <= '0; vy <= '0; color_r <= '0;
            xmin_r <= '0; xmax_r <= '0; ymax_r <= '0;
            px <= '0; py <= '0; scan_end <= 1'b0;
            frag_valid <= 1'b0; frag_x <= '0; frag_y <= '0; frag_color <= '0;
        end else begin
            if (frag_valid && frag_ready) frag_valid <= 1'b0;
            case (state)
                S_IDLE: if (tri_valid) begin
                    vx <= tri_x; vy <= tri_y; color_r <= tri_color;
                end
                S_SETUP: begin
                    xmin_r <= xmin_c; xmax_r <= xmax_c; ymax_r <= ymax_c;
                    px <= xmin_c; py <= ymin_c;
                    scan_end <= 1'b0;
                end
                S_SCAN: if (!scan_end && !stall) begin
                    if (covered) begin
                        frag_valid <= 1'b1;
                        frag_x     <= XW'(px);
                        frag_y     <= YW'(py);
                        frag_color <= color_r;
                    end
                    if (px == xmax_r) begin
                        if (py == ymax_r) scan_end <= 1'b1;
                        else begin
                            px <= xmin_r;
                            py <= py + CW'(1);
                        end
                    end else begin
                        px <= px + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_raster_stream.sv
// Randomised and directed bench for tri_raster_stream with a queue-based scoreboard
// fed by a whole-screen coverage model.
module tb_tri_raster_stream;
    localparam int WIDTH = 64, HEIGHT = 64, CW = 9, COLOR_W = 8;
    localparam int XW = 6, YW = 6, W = XW + YW + COLOR_W;

    logic clk, rst_in, tri_valid, tri_ready, frag_valid, frag_ready, tri_done, busy;
    logic [3*CW-1:0] tri_x, tri_y;
    logic [COLOR_W-1:0] tri_color, frag_color;
    logic [XW-1:0] frag_x;
    logic [YW-1:0] frag_y;

    tri_raster_stream #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW), .COLOR_W(COLOR_W)) dut (
        .clk_in(clk), .rst_in(rst_in), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_x(tri_x), .tri_y(tri_y), .tri_color(tri_color), .frag_valid(frag_valid),
        .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y), .frag_color(frag_color),
        .tri_done(tri_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [W-1:0] exp_q[$];
    int acc_count = 0, dones_seen = 0, done_expected = 0;
    bit hold_pending = 0;
    logic [W-1:0] held;
    bit rdy_rand = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint edge_val(input int ax, ay, bx, by, qx, qy);
        return longint'(bx - ax) * (qy - ay) - longint'(by - ay) * (qx - ax);
    endfunction

    // Reference: every on-screen pixel, row-major, that lies inside or on the triangle.
    task automatic model_push(input int x0, y0, x1, y1, x2, y2, input int c);
        longint e0, e1, e2;
        if (edge_val(x0, y0, x1, y1, x2, y2) == 0) return;
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) begin
                e0 = edge_val(x0, y0, x1, y1, x, y);
                e1 = edge_val(x1, y1, x2, y2, x, y);
                e2 = edge_val(x2, y2, x0, y0, x, y);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
                    exp_q.push_back({XW'(x), YW'(y), COLOR_W'(c)});
            end
    endtask

    // Monitor: pops on every accepted fragment, checks stability while stalled.
    initial begin
        logic [W-1:0] act, e;
        forever begin
            @(negedge clk);
            if (!rst_in) begin
                act = {frag_x, frag_y, frag_color};
                if (hold_pending) begin
                    check("stall_valid_held", frag_valid, 1);
                    check("stall_data_held", act, held);
                    hold_pending = 0;
                end
                if (frag_valid) begin
                    if (frag_ready) begin
                        acc_count++;
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL frag_unexpected: got x=%0d y=%0d c=%0h, none required",
                                     frag_x, frag_y, frag_color);
                        end else begin
                            e = exp_q.pop_front();
                            check("frag_xyc", act, e);
                        end
                    end else begin
                        hold_pending = 1;
                        held = act;
                    end
                end
                if (tri_done) begin
                    dones_seen++;
                    check("done_after_all_frags", exp_q.size(), 0);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_rand) frag_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send_tri(input int x0, y0, x1, y1, x2, y2, input int c);
        int n = 0;
        @(negedge clk);
        while (!tri_ready && n < 20000) begin @(negedge clk); n++; end
        if (!tri_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: tri_ready=0 required 1");
        end
        model_push(x0, y0, x1, y1, x2, y2, c);
        done_expected++;
        tri_x = {CW'(x2), CW'(x1), CW'(x0)};
        tri_y = {CW'(y2), CW'(y1), CW'(y0)};
        tri_color = COLOR_W'(c);
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
    endtask

    task automatic poke_busy();
        tri_x = 27'($urandom); tri_y = 27'($urandom); tri_color = 8'($urandom);
        tri_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        tri_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=1 required 0");
        end
        @(negedge clk);
    endtask

    initial begin
        int a0, d0, n, bx, by;
        rst_in = 1'b1; tri_valid = 1'b0; frag_ready = 1'b1;
        tri_x = '0; tri_y = '0; tri_color = '0;
        #1 rst_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tri_ready", tri_ready, 1);
        check("rst_frag_valid", frag_valid, 0);
        check("rst_frag_x", frag_x, 0);
        check("rst_frag_y", frag_y, 0);
        check("rst_frag_color", frag_color, 0);
        check("rst_tri_done", tri_done, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #2 rst_in = 1'b0;

        // Basic triangle with first-fragment latency.
        a0 = acc_count;
        send_tri(0, 0, 3, 0, 0, 3, 'hA5);
        @(negedge clk); check("lat_setup_no_frag", frag_valid, 0);
        @(negedge clk); check("lat_scan_no_frag", frag_valid, 0);
        @(negedge clk); check("lat_first_frag", frag_valid, 1);
        wait_idle();
        check("t1_frag_count", acc_count - a0, 10);

        a0 = acc_count;
        send_tri(0, 0, 0, 3, 3, 0, 'hA5);
        wait_idle();
        check("rev_frag_count", acc_count - a0, 10);

        // Collinear: straight to DONE.
        a0 = acc_count;
        send_tri(0, 0, 2, 2, 4, 4, 'h11);
        @(negedge clk); check("col_done_c1", tri_done, 0);
        @(negedge clk); check("col_done_c2", tri_done, 1);
        @(negedge clk); check("col_ready_c3", tri_ready, 1);
        check("col_done_c3_low", tri_done, 0);
        check("col_frag_count", acc_count - a0, 0);

        a0 = acc_count; d0 = dones_seen;
        send_tri(100, 100, 120, 100, 100, 120, 'h22);
        wait_idle();
        check("off_frag_count", acc_count - a0, 0);
        check("off_done_count", dones_seen - d0, 1);

        send_tri(60, 0, 70, 0, 60, 10, 'h33);
        wait_idle();

        // Backpressure after the 3rd fragment.
        a0 = acc_count;
        send_tri(0, 0, 3, 0, 0, 3, 'hA5);
        n = 0;
        while (acc_count < a0 + 3 && n < 100) begin @(posedge clk); n++; end
        check("bp_reached_3", (acc_count >= a0 + 3) ? 1 : 0, 1);
        #1 frag_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 frag_ready = 1'b1;
        wait_idle();
        check("bp_frag_count", acc_count - a0, 10);

        // Reset in the middle of a scan.
        rdy_rand = 1;
        send_tri(0, 0, 20, 0, 0, 20, 'h5A);
        repeat (8) @(posedge clk);
        #2 rst_in = 1'b1;
        #1;
        check("mid_rst_frag_valid", frag_valid, 0);
        check("mid_rst_frag_x", frag_x, 0);
        check("mid_rst_frag_y", frag_y, 0);
        check("mid_rst_frag_color", frag_color, 0);
        check("mid_rst_tri_done", tri_done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tri_ready", tri_ready, 1);
        exp_q.delete();
        done_expected--;
        hold_pending = 0;
        @(posedge clk); #2 rst_in = 1'b0;
        send_tri(5, 5, 12, 7, 6, 14, 'h77);
        wait_idle();

        // Random triangles under random backpressure, with ignored offers while busy.
        for (int i = 0; i < 25; i++) begin
            bx = $urandom_range(0, 72);
            by = $urandom_range(0, 72);
            if (i % 6 == 0)
                send_tri(bx, by, bx, by + $urandom_range(0, 9), bx, by + $urandom_range(0, 9),
                         $urandom_range(0, 255));
            else
                send_tri(bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                         bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                         bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                         $urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) poke_busy();
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();
        rdy_rand = 0;
        frag_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("final_done_count", dones_seen, done_expected);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
